// File: rtl/tour_len_seq.sv
// tour_len_seq
//   Walks a closed tour over N points and accumulates its total Manhattan
//   length, including the closing edge from the last point back to the first.
//   The visiting order comes from an external order table (registered read,
//   one cycle latency). Coordinates come from the point arrays, which are
//   read combinationally.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            request one tour evaluation (sampled in IDLE only)
//   pts_ready        point arrays valid; the run waits for it before starting
//   ord_addr         tour position presented to the order table (= k)
//   ord_idx          point index returned by the order table
//   pt_addr          point index presented to the point arrays (= ord_idx)
//   pt_x, pt_y       coordinates of point pt_addr
//   busy             high while a run is pending or in progress
//   done             one-cycle pulse; total_len is valid from this cycle
//   total_len        last completed tour length, held until the next done
module tour_len_seq #(
  parameter int N       = 64,
  parameter int IDX_W   = 6,
  parameter int COORD_W = 8,
  parameter int ACC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pts_ready,
  output logic [IDX_W-1:0]   ord_addr,
  input  logic [IDX_W-1:0]   ord_idx,
  output logic [IDX_W-1:0]   pt_addr,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   total_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PTS,
    S_RD_ORD,
    S_LD_PT,
    S_CLOSE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

  state_t             state;
  logic [IDX_W-1:0]   k;
  logic [ACC_W-1:0]   acc;
  logic [COORD_W-1:0] first_x, first_y;
  logic [COORD_W-1:0] prev_x, prev_y;
  logic [COORD_W:0]   step_len;
  logic [COORD_W:0]   close_len;
  logic [ACC_W-1:0]   close_sum;

  // |a-b| without a sign bit: subtract the smaller from the larger.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign ord_addr = k;
  assign pt_addr  = ord_idx;

  always_comb begin
    step_len  = {1'b0, abs_diff(pt_x, prev_x)} + {1'b0, abs_diff(pt_y, prev_y)};
    close_len = {1'b0, abs_diff(first_x, prev_x)} + {1'b0, abs_diff(first_y, prev_y)};
    close_sum = acc + ACC_W'(close_len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      acc       <= '0;
      total_len <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      first_x   <= '0;
      first_y   <= '0;
      prev_x    <= '0;
      prev_y    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            k     <= '0;
            acc   <= '0;
            state <= pts_ready ? S_RD_ORD : S_WAIT_PTS;
          end
        end
        S_WAIT_PTS: begin
          if (pts_ready) begin
            k     <= '0;
            acc   <= '0;
            state <= S_RD_ORD;
          end
        end
        S_RD_ORD: begin
          state <= S_LD_PT;
        end
        S_LD_PT: begin
          prev_x <= pt_x;
          prev_y <= pt_y;
          if (k == '0) begin
            first_x <= pt_x;
            first_y <= pt_y;
          end else begin
            acc <= acc + ACC_W'(step_len);
          end
          if (k == K_LAST) begin
            state <= S_CLOSE;
          end else begin
            k     <= k + IDX_W'(1);
            state <= S_RD_ORD;
          end
        end
        S_CLOSE: begin
          // Result and done are registered here so both are already visible
          // during the DONE cycle.
          acc       <= close_sum;
          total_len <= close_sum;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          k     <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
